mypio_multi: RTL and testbench

Next-generation custom PIO for the Nios II Qsys system on DE1-SoC. It is an Avalon-MM slave that drives N_DIGITS active-low 7-segment digits, with per-digit blank and blink control. It also samples an IN_WIDTH-bit input port (slide/push switches) with synchronisation, rising-edge capture and a maskable interrupt. Exported conduits connect to the HEXn and SW/KEY pins in the top level.

---
 rtl/mypio_multi.sv | 137 +++++++++++++
 tb/tb_mypio_multi.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/mypio_multi.sv
// Avalon-MM PIO: active-low 7-segment digits with blank/blink plus a synchronised input port.
// Edge capture on the input port raises a maskable interrupt.
module mypio_multi #(
  parameter int N_DIGITS  = 6,
  parameter int IN_WIDTH  = 4,
  parameter int BLINK_DIV = 25000000
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [2:0]            avs_address,
  input  logic                  avs_read,
  input  logic                  avs_write,
  input  logic [31:0]           avs_writedata,
  output logic [31:0]           avs_readdata,
  output logic                  ins_irq,
  input  logic [IN_WIDTH-1:0]   coe_in,
  output logic [7*N_DIGITS-1:0] coe_nhex
);
  localparam int CW = $clog2(BLINK_DIV);
  localparam int DW = 4 * N_DIGITS;

  logic [DW-1:0]         r_data;
  logic [N_DIGITS-1:0]   r_blank;
  logic [N_DIGITS-1:0]   r_blink;
  logic [IN_WIDTH-1:0]   r_sync1;
  logic [IN_WIDTH-1:0]   r_sync_q;
  logic [IN_WIDTH-1:0]   r_prev_q;
  logic [IN_WIDTH-1:0]   r_edge;
  logic [IN_WIDTH-1:0]   r_mask;
  logic [1:0]            r_fill;
  logic [CW-1:0]         r_cnt;
  logic                  r_phase;
  logic [31:0]           r_rdata;
  logic                  r_irq;
  logic [7*N_DIGITS-1:0] r_nhex;

  logic [IN_WIDTH-1:0]   w_rise;
  logic [IN_WIDTH-1:0]   w_clr;
  logic [31:0]           w_rdata;
  logic [7*N_DIGITS-1:0] w_nhex;

  function automatic logic [6:0] f_seg(input logic [3:0] v);
    case (v)
      4'h0: f_seg = 7'h40;  4'h1: f_seg = 7'h79;  4'h2: f_seg = 7'h24;  4'h3: f_seg = 7'h30;
      4'h4: f_seg = 7'h19;  4'h5: f_seg = 7'h12;  4'h6: f_seg = 7'h02;  4'h7: f_seg = 7'h78;
      4'h8: f_seg = 7'h00;  4'h9: f_seg = 7'h10;  4'hA: f_seg = 7'h08;  4'hB: f_seg = 7'h03;
      4'hC: f_seg = 7'h46;  4'hD: f_seg = 7'h21;  4'hE: f_seg = 7'h06;  default: f_seg = 7'h0E;
    endcase
  endfunction

  // Edges are ignored until prev_q has seen a synchronised sample, so a level
  // already high when reset releases never counts as a rising edge.
  assign w_rise = (r_fill == 2'd3) ? (r_sync_q & ~r_prev_q) : '0;
  assign w_clr  = (avs_write && avs_address == 3'd4) ? avs_writedata[IN_WIDTH-1:0] : '0;

  always_comb begin
    w_rdata = '0;
    case (avs_address)
      3'd0:    w_rdata[DW-1:0]       = r_data;
      3'd1:    w_rdata[N_DIGITS-1:0] = r_blank;
      3'd2:    w_rdata[N_DIGITS-1:0] = r_blink;
      3'd3:    w_rdata[IN_WIDTH-1:0] = r_sync_q;
      3'd4:    w_rdata[IN_WIDTH-1:0] = r_edge;
      3'd5:    w_rdata[IN_WIDTH-1:0] = r_mask;
      default: w_rdata = '0;
    endcase
  end

  always_comb begin
    w_nhex = '1;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (!(r_blank[k] || (r_blink[k] && r_phase)))
        w_nhex[7*k +: 7] = f_seg(r_data[4*k +: 4]);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_data  <= '0;
      r_blank <= '0;
      r_blink <= '0;
      r_mask  <= '0;
      r_rdata <= '0;
    end else begin
      if (avs_write) begin
        case (avs_address)
          3'd0:    r_data  <= avs_writedata[DW-1:0];
          3'd1:    r_blank <= avs_writedata[N_DIGITS-1:0];
          3'd2:    r_blink <= avs_writedata[N_DIGITS-1:0];
          3'd5:    r_mask  <= avs_writedata[IN_WIDTH-1:0];
          default: ;
        endcase
      end
      if (avs_read)
        r_rdata <= w_rdata;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_sync1  <= '0;
      r_sync_q <= '0;
      r_prev_q <= '0;
      r_fill   <= '0;
      r_edge   <= '0;
      r_irq    <= 1'b0;
    end else begin
      r_sync1  <= coe_in;
      r_sync_q <= r_sync1;
      r_prev_q <= r_sync_q;
      if (r_fill != 2'd3)
        r_fill <= r_fill + 2'd1;
      r_edge <= (r_edge & ~w_clr) | w_rise;
      r_irq  <= |(r_edge & r_mask);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_cnt   <= '0;
      r_phase <= 1'b0;
      r_nhex  <= '1;
    end else begin
      if (r_cnt == CW'(BLINK_DIV - 1)) begin
        r_cnt   <= '0;
        r_phase <= ~r_phase;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
      r_nhex <= w_nhex;
    end
  end

  assign avs_readdata = r_rdata;
  assign ins_irq      = r_irq;
  assign coe_nhex     = r_nhex;
endmodule

// File: tb/tb_mypio_multi.sv
// Directed bench for mypio_multi: register map, digit decode, blink timing,
// edge capture / interrupt and asynchronous reset behaviour.
module tb_mypio_multi;
  localparam int ND = 6;
  localparam int IW = 4;
  localparam int BD = 4;

  logic          CLK = 1'b0;
  logic          RST;
  logic [2:0]    avs_address;
  logic          avs_read;
  logic          avs_write;
  logic [31:0]   avs_writedata;
  logic [31:0]   avs_readdata;
  logic          ins_irq;
  logic [IW-1:0] coe_in;
  logic [7*ND-1:0] coe_nhex;

  int n_tests = 0;
  int n_fail  = 0;

  mypio_multi #(.N_DIGITS(ND), .IN_WIDTH(IW), .BLINK_DIV(BD)) dut (
    .CLK(CLK), .RST(RST),
    .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
    .avs_writedata(avs_writedata), .avs_readdata(avs_readdata),
    .ins_irq(ins_irq), .coe_in(coe_in), .coe_nhex(coe_nhex)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] data;
    logic [31:0] blank;
    logic [41:0] nhex;
    logic [31:0] data_rd;
    logic [31:0] blank_rd;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // All tasks are entered just after a falling edge and return just after one.
  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    avs_address = a; avs_writedata = d; avs_write = 1'b1;
    @(negedge CLK);
    avs_write = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    avs_address = a; avs_read = 1'b1;
    @(negedge CLK);
    avs_read = 1'b0;
    d = avs_readdata;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected finish before 200000");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] rv;
    logic [6:0]  s[17];
    int bad1, bad2, bad0, t0, lat;
    bit found;

    vecs[0] = '{32'h00A5_3210, 32'h0000_0000,
                {7'h08, 7'h12, 7'h30, 7'h24, 7'h79, 7'h40}, 32'h00A5_3210, 32'h0};
    vecs[1] = '{32'hFFFE_DCBA, 32'h0000_0000,
                {7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08}, 32'h00FE_DCBA, 32'h0};
    vecs[2] = '{32'h0098_7654, 32'h0000_003F,
                {6{7'h7F}}, 32'h0098_7654, 32'h3F};
    vecs[3] = '{32'h0098_7654, 32'hFFFF_FF05,
                {7'h10, 7'h00, 7'h78, 7'h7F, 7'h12, 7'h7F}, 32'h0098_7654, 32'h05};

    RST = 1'b1; avs_address = '0; avs_read = 1'b0; avs_write = 1'b0;
    avs_writedata = '0; coe_in = '0;
    tick(3);
    check("reset_nhex", 64'(coe_nhex), 64'h3FF_FFFF_FFFF);
    check("reset_irq", 64'(ins_irq), 64'h0);
    check("reset_rdata", 64'(avs_readdata), 64'h0);
    RST = 1'b0;
    tick(1);
    for (int a = 0; a < 8; a++) begin
      rd(3'(a), rv);
      check($sformatf("reset_read_%0d", a), 64'(rv), 64'h0);
    end

    wr(3'd3, 32'hF);
    rd(3'd3, rv);
    check("ro_write_ignored", 64'(rv), 64'h0);
    wr(3'd6, 32'hFFFF_FFFF);
    rd(3'd6, rv);
    check("unused_addr_read", 64'(rv), 64'h0);

    for (int i = 0; i < 4; i++) begin
      wr(3'd0, vecs[i].data);
      wr(3'd1, vecs[i].blank);
      tick(1);
      check($sformatf("vec%0d_nhex", i), 64'(coe_nhex), 64'(vecs[i].nhex));
      rd(3'd0, rv);
      check($sformatf("vec%0d_data_rd", i), 64'(rv), 64'(vecs[i].data_rd));
      rd(3'd1, rv);
      check($sformatf("vec%0d_blank_rd", i), 64'(rv), 64'(vecs[i].blank_rd));
    end

    // Blink: digit0 blinks with runs of BD cycles, digit1 blanked, digit2 steady.
    wr(3'd0, 32'h00A5_3210);
    wr(3'd1, 32'h02);
    wr(3'd2, 32'h01);
    tick(1);
    bad1 = 0; bad2 = 0; bad0 = 0;
    for (int i = 0; i < 17; i++) begin
      s[i] = coe_nhex[6:0];
      if (coe_nhex[13:7] !== 7'h7F) bad1++;
      if (coe_nhex[20:14] !== 7'h24) bad2++;
      if (s[i] !== 7'h40 && s[i] !== 7'h7F) bad0++;
      tick(1);
    end
    check("blink_digit1_dark", 64'(bad1), 64'h0);
    check("blink_digit2_steady", 64'(bad2), 64'h0);
    check("blink_digit0_values", 64'(bad0), 64'h0);
    t0 = 0;
    for (int i = 1; i <= 4; i++)
      if (t0 == 0 && s[i] !== s[i-1]) t0 = i;
    check("blink_toggle_seen", 64'(t0 != 0), 64'h1);
    if (t0 != 0) begin
      bad0 = 0;
      for (int i = t0; i < t0 + 12; i++)
        if (s[i] !== ((((i - t0) / BD) % 2 == 0) ? s[t0] : s[t0-1])) bad0++;
      check("blink_period", 64'(bad0), 64'h0);
    end

    avs_address = 3'd0; avs_writedata = 32'h11; avs_write = 1'b1; avs_read = 1'b1;
    tick(1);
    avs_write = 1'b0; avs_read = 1'b0;
    check("rd_wr_same_cycle", 64'(avs_readdata), 64'h00A5_3210);
    rd(3'd0, rv);
    check("rd_after_wr", 64'(rv), 64'h11);

    wr(3'd5, 32'h1);
    coe_in[0] = 1'b1;
    found = 0; lat = 0;
    for (int i = 1; i <= 8; i++) begin
      if (!found) begin
        tick(1);
        if (ins_irq) begin found = 1; lat = i; end
      end
    end
    check("irq_latency", 64'(lat), 64'd4);
    rd(3'd4, rv);
    check("edge_bit0", 64'(rv), 64'h1);
    rd(3'd3, rv);
    check("in_value", 64'(rv), 64'h1);
    wr(3'd4, 32'h1);
    tick(1);
    check("irq_cleared", 64'(ins_irq), 64'h0);
    rd(3'd4, rv);
    check("edge_cleared", 64'(rv), 64'h0);
    coe_in[1] = 1'b1;
    tick(5);
    rd(3'd4, rv);
    check("edge_bit1_unmasked", 64'(rv), 64'h2);
    check("irq_masked_off", 64'(ins_irq), 64'h0);

    coe_in[0] = 1'b0;
    tick(4);
    coe_in[0] = 1'b1;
    tick(6);
    check("irq_rearmed", 64'(ins_irq), 64'h1);
    coe_in[0] = 1'b0;
    tick(4);
    coe_in[0] = 1'b1;
    tick(2);
    wr(3'd4, 32'h1);
    check("set_wins_irq_a", 64'(ins_irq), 64'h1);
    tick(1);
    check("set_wins_irq_b", 64'(ins_irq), 64'h1);
    rd(3'd4, rv);
    check("set_wins_edge", 64'(rv), 64'h3);

    wr(3'd5, 32'h0);
    tick(1);
    check("mask_clear_irq", 64'(ins_irq), 64'h0);
    rd(3'd4, rv);
    check("mask_clear_keeps_edge", 64'(rv), 64'h3);
    wr(3'd0, 32'h0);
    wr(3'd5, 32'h1);
    tick(2);
    check("irq_pending_pre_reset", 64'(ins_irq), 64'h1);

    RST = 1'b1;
    #1;
    check("async_reset_irq", 64'(ins_irq), 64'h0);
    check("async_reset_nhex", 64'(coe_nhex), 64'h3FF_FFFF_FFFF);
    @(negedge CLK);
    RST = 1'b0;
    tick(6);
    check("post_reset_irq", 64'(ins_irq), 64'h0);
    check("post_reset_nhex", 64'(coe_nhex), 64'({6{7'h40}}));
    rd(3'd4, rv);
    check("post_reset_no_edge", 64'(rv), 64'h0);
    rd(3'd3, rv);
    check("post_reset_in", 64'(rv), 64'h3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
